adc_capture_buffer: RTL and testbench

Sits directly downstream of the LVDS/IDDR input stage. It takes the per-DCO-cycle sample pair (rising-edge byte = channel A, falling-edge byte = channel B) and writes it continuously into a circular on-chip RAM. When armed, it captures a pre/post-trigger window around a level-crossing or forced trigger. The frozen window is then streamed out over a valid/ready interface toward the MicroBlaze MCS GPIO bridge.

---
 rtl/adc_capture_buffer.sv | 183 ++++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer.sv
// Circular capture RAM for the IDDR sample pair, with a pre/post-trigger window streamed out over valid/ready.
// Optional ramp pattern checker is compiled in when ADC_CAPTURE_PATTERN_CHECK_EN is defined.
module adc_capture_buffer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRETRIG    = 64
) (
    input  logic        adc_dco_clk,
    input  logic        reset_n,
    input  logic [7:0]  adc_data_p,
    input  logic [7:0]  adc_data_n,
    input  logic        arm,
    input  logic        force_trig,
    input  logic [7:0]  trig_level,
    input  logic        trig_en,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic        busy,
    output logic [2:0]  state,
    output logic [15:0] pattern_err_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRETRIG - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRETRIG - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PRETRIG_C = PTR_W'(PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READ      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] start_addr;
    logic [PTR_W-1:0] rd_addr;
    logic [PTR_W-1:0] trig_start;
    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] post_cnt;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [7:0]       prev_a;
    logic [7:0]       prev_a_eff;
    logic             prev_vld;
    logic             level_hit;
    logic             trig_hit;
    logic             wr_en;
    logic             rd_advance;
    logic             rd_issue;
    logic [15:0]      ram_q_p1;
    logic             vld_p1;
    logic [15:0]      mem [DEPTH];

    // prev_a is meaningless on the first cycle out of IDLE; 0xFF there can never satisfy prev_a < level.
    always_comb begin
        prev_a_eff = prev_vld ? prev_a : 8'hFF;
        level_hit  = trig_en && (prev_a_eff < trig_level) && (adc_data_p >= trig_level);
        trig_hit   = (state_q == S_WAIT_TRIG) && (force_trig || level_hit);
        trig_start = wr_ptr - PRETRIG_C;
        wr_en      = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
        rd_advance = !rd_valid || rd_ready;
        rd_issue   = (state_q == S_READ) && rd_advance && (issue_cnt < DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (arm) state_d = S_PRE;
            S_PRE:       if (pre_cnt == PRE_LAST) state_d = S_WAIT_TRIG;
            S_WAIT_TRIG: if (trig_hit) state_d = (POST_LAST == '0) ? S_READ : S_POST;
            S_POST:      if (post_cnt == POST_LAST) state_d = S_READ;
            S_READ:      if (rd_valid && rd_ready && rd_last) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        state   = state_q;
        rd_last = rd_valid && (rd_cnt == LAST_IDX);
    end

    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr     <= '0;
            start_addr <= '0;
            rd_addr    <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            issue_cnt  <= '0;
            rd_cnt     <= '0;
            prev_vld   <= 1'b0;
            vld_p1     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            state_q  <= state_d;
            prev_vld <= (state_q != S_IDLE);
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);

            if (state_q == S_IDLE && arm) pre_cnt <= '0;
            else if (state_q == S_PRE)    pre_cnt <= pre_cnt + CNT_W'(1);

            if (trig_hit) begin
                post_cnt   <= CNT_W'(1);
                start_addr <= trig_start;
            end else if (state_q == S_POST) begin
                post_cnt <= post_cnt + CNT_W'(1);
            end

            // Readout: p1 = registered RAM output, then the output register; both stall together.
            if (state_q != S_READ) begin
                vld_p1    <= 1'b0;
                rd_valid  <= 1'b0;
                issue_cnt <= '0;
                rd_cnt    <= '0;
                if (state_d == S_READ)
                    rd_addr <= (state_q == S_WAIT_TRIG) ? trig_start : start_addr;
            end else begin
                if (rd_advance) begin
                    vld_p1   <= rd_issue;
                    rd_valid <= vld_p1;
                    if (vld_p1) rd_data <= ram_q_p1;
                end
                if (rd_issue) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    rd_addr   <= rd_addr + PTR_W'(1);
                end
                if (rd_valid && rd_ready) rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge adc_dco_clk) begin
        prev_a <= adc_data_p;
        if (wr_en)    mem[wr_ptr] <= {adc_data_n, adc_data_p};
        if (rd_issue) ram_q_p1    <= mem[rd_addr];
    end

`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    logic [7:0]  pc_prev_a;
    logic        pc_seeded;
    logic        pc_mismatch;
    logic [15:0] pc_err_cnt;

    always_comb begin
        pc_mismatch = (adc_data_p != pc_prev_a + 8'd1) || (adc_data_n != adc_data_p);
    end

    always_ff @(posedge adc_dco_clk) begin
        if (!reset_n) begin
            pc_seeded  <= 1'b0;
            pc_err_cnt <= '0;
        end else begin
            pc_seeded <= 1'b1;
            if (arm)
                pc_err_cnt <= '0;
            else if (pc_seeded && pc_mismatch && pc_err_cnt != 16'hFFFF)
                pc_err_cnt <= pc_err_cnt + 16'd1;
        end
    end

    always_ff @(posedge adc_dco_clk) begin
        pc_prev_a <= adc_data_p;
    end

    assign pattern_err_cnt = pc_err_cnt;
`else
    assign pattern_err_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Scoreboard bench for adc_capture_buffer (DEPTH_LOG2=4, PRETRIG=4): driven samples inside the
// expected capture window are queued and compared against each readout transfer.
module tb_adc_capture_buffer;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int PRETRIG    = 4;
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    localparam int EXP_ERR = 3;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  adc_data_p, adc_data_n;
    logic        arm, force_trig, trig_en;
    logic [7:0]  trig_level;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready, rd_last, busy;
    logic [2:0]  state;
    logic [15:0] pattern_err_cnt;

    adc_capture_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .PRETRIG(PRETRIG)) dut (
        .adc_dco_clk(clk), .reset_n(reset_n),
        .adc_data_p(adc_data_p), .adc_data_n(adc_data_n),
        .arm(arm), .force_trig(force_trig), .trig_level(trig_level), .trig_en(trig_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .state(state), .pattern_err_cnt(pattern_err_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc = 0, win_lo = 1, win_hi = 0, xfers = 0, read_age = -1;
    int          rp_idx = 0, ready_mode = 0;
    bit          first_vld = 1'b0, stall_prev = 1'b0, corrupt_b = 1'b0;
    logic [3:0]  rp_pat = 4'b1001;
    logic [7:0]  ramp_val = 8'h00;
    logic [15:0] held_data;
    logic [15:0] exp_q[$];
    logic [15:0] got_data[DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus, score the handshake about to happen, then advance past the edge.
    task automatic tick();
        logic [7:0]  a, b;
        logic [15:0] e;
        logic        present;
        a = ramp_val;
        b = corrupt_b ? (ramp_val ^ 8'h55) : ramp_val;
        adc_data_p = a;
        adc_data_n = b;
        rd_ready   = (ready_mode == 0) ? 1'b1 : rp_pat[rp_idx];
        rp_idx     = (rp_idx + 1) % 4;
        if (cyc >= win_lo && cyc <= win_hi) exp_q.push_back({b, a});
        if (reset_n) begin
            if (stall_prev) begin
                check("hold_data", rd_data, held_data);
                check("hold_valid", rd_valid, 1);
            end
            if (state == 3'd4 && rd_valid && first_vld) begin
                check("vld_latency", read_age <= 2, 1);
                first_vld = 1'b0;
            end
            if (rd_valid && rd_ready) begin
                present = (exp_q.size() != 0);
                e = present ? exp_q.pop_front() : 16'h0000;
                check("rd_data", {1'b1, rd_data}, {present, e});
                check("rd_last", rd_last, xfers == DEPTH - 1);
                if (xfers < DEPTH) got_data[xfers] = rd_data;
                xfers++;
            end
            stall_prev = rd_valid && !rd_ready;
            held_data  = rd_data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        ramp_val++;
        read_age = (state == 3'd4) ? read_age + 1 : -1;
    endtask

    task automatic apply_reset();
        win_lo = 1;
        win_hi = 0;
        exp_q.delete();
        force_trig = 1'b0;
        trig_en    = 1'b0;
        reset_n    = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_state", state, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", rd_last, 0);
    endtask

    // trig_off: edges from the arm edge to the expected trigger edge.
    // abort_at > 0 applies reset at that loop step after first checking the state is abort_state.
    task automatic do_capture(input bit lvl, input int trig_off, input int abort_at,
                              input logic [2:0] abort_state, input bit corrupt);
        bit aborted;
        aborted   = 1'b0;
        win_lo    = cyc + trig_off - PRETRIG;
        win_hi    = cyc + trig_off + DEPTH - PRETRIG - 1;
        xfers     = 0;
        first_vld = 1'b1;
        trig_en    = lvl;
        trig_level = 8'h80;
        force_trig = !lvl;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_state", state, 1);
        check("arm_busy", busy, 1);
        for (int i = 1; i <= 300; i++) begin
            if (i == abort_at) begin
                check("pre_abort_state", state, abort_state);
                apply_reset();
                aborted = 1'b1;
                break;
            end
            if (state == 3'd0) break;
            corrupt_b = corrupt && (i == 7 || i == 9 || i == 11);
            tick();
        end
        corrupt_b  = 1'b0;
        force_trig = 1'b0;
        trig_en    = 1'b0;
        if (!aborted) begin
            check("xfer_count", xfers, DEPTH);
            check("queue_empty", exp_q.size(), 0);
            check("end_state", state, 0);
            check("end_busy", busy, 0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        arm        = 1'b0;
        force_trig = 1'b0;
        trig_en    = 1'b0;
        trig_level = 8'h80;
        rd_ready   = 1'b1;
        adc_data_p = 8'h00;
        adc_data_n = 8'h00;
        tick();
        apply_reset();
        check("rst_data", rd_data, 0);
        check("rst_pattern", pattern_err_cnt, 0);

        // Forced trigger held from arming fires on the first WAIT_TRIG cycle.
        do_capture(1'b0, PRETRIG + 1, 0, 3'd0, 1'b0);

        // Level trigger: A crosses 0x80 nineteen edges after arm, leaving wr_ptr at 14.
        ramp_val = 8'h6D;
        do_capture(1'b1, 19, 0, 3'd0, 1'b0);
        check("level_trig_sample", got_data[PRETRIG], 16'h8080);

        // Window start wraps through address 0, read out under 1,0,0,1 backpressure.
        ready_mode = 1;
        do_capture(1'b0, PRETRIG + 1, 0, 3'd0, 1'b0);
        ready_mode = 0;

        // Reset during POST, then during READ, then a clean capture.
        do_capture(1'b0, PRETRIG + 1, 8, 3'd3, 1'b0);
        do_capture(1'b0, PRETRIG + 1, 24, 3'd4, 1'b0);
        do_capture(1'b0, PRETRIG + 1, 0, 3'd0, 1'b0);

        // Three isolated channel-B corruptions after arm.
        do_capture(1'b0, PRETRIG + 1, 0, 3'd0, 1'b1);
        check("pattern_err_cnt", pattern_err_cnt, EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
